// File: rtl/nos_dac_transmitter.sv
// Parallel-to-serial transmitter for the NOS DAC interface: one-pair skid register, MSB-first shift, divided bck.
// Optional build macro NOS_TX_MUTE_EN adds a mute input that zeroes words at load time.
module nos_dac_transmitter #(
  parameter int WIDTH   = 32,
  parameter int BCK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef NOS_TX_MUTE_EN
  input  logic             mute,
`endif
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data_l,
  input  logic [WIDTH-1:0] s_data_r,
  output logic             bck,
  output logic             data_l,
  output logic             data_r,
  output logic             le,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             hold_full;
  logic             hold_full_next;
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] sh_l;
  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             mute_s;
  logic             div_tc;
  logic             bck_fall;
  logic             word_end;
  logic             load;
  logic             accept;

`ifdef NOS_TX_MUTE_EN
  assign mute_s = mute;
`else
  assign mute_s = 1'b0;
`endif

  assign data_l   = sh_l[WIDTH-1];
  assign data_r   = sh_r[WIDTH-1];
  assign div_tc   = (div_cnt == DIV_LAST);
  assign bck_fall = (state == ST_SHIFT) && div_tc && bck;
  assign word_end = bck_fall && (bit_cnt == {CW{1'b0}});
  // A word end with a full hold register reloads on the same edge, keeping bck continuous.
  assign load     = (state == ST_LOAD) || (word_end && hold_full);
  assign accept   = s_valid && s_ready;

  // Next-state selection for the transmit FSM.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (word_end && !hold_full) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Hold occupancy: a new accept always lands after any same-edge reload has taken the old contents.
  always_comb begin
    hold_full_next = hold_full;
    if (accept) begin
      hold_full_next = 1'b1;
    end else if (load) begin
      hold_full_next = 1'b0;
    end else begin
      hold_full_next = hold_full;
    end
  end

  // Handshake, hold register, divider, shifter and serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      hold_l    <= {WIDTH{1'b0}};
      hold_r    <= {WIDTH{1'b0}};
      sh_l      <= {WIDTH{1'b0}};
      sh_r      <= {WIDTH{1'b0}};
      bit_cnt   <= {CW{1'b0}};
      div_cnt   <= {DW{1'b0}};
      bck       <= 1'b0;
      le        <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != ST_IDLE);
      hold_full <= hold_full_next;
      s_ready   <= !hold_full_next;
      if (accept) begin
        hold_l <= s_data_l;
        hold_r <= s_data_r;
      end
      if (load) begin
        sh_l    <= mute_s ? {WIDTH{1'b0}} : hold_l;
        sh_r    <= mute_s ? {WIDTH{1'b0}} : hold_r;
        bit_cnt <= BIT_LAST;
        div_cnt <= {DW{1'b0}};
        bck     <= 1'b0;
        le      <= (WIDTH == 1);
      end else if (state == ST_SHIFT) begin
        if (div_tc) begin
          div_cnt <= {DW{1'b0}};
          bck     <= !bck;
          if (bck) begin
            if (word_end) begin
              sh_l <= {WIDTH{1'b0}};
              sh_r <= {WIDTH{1'b0}};
              le   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - CW'(1);
              sh_l    <= sh_l << 1;
              sh_r    <= sh_r << 1;
              le      <= (bit_cnt == CW'(1));
            end
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule
